// File: rtl/obstacle_spawner_pkg.sv
// Shared definitions for the obstacle spawner slice.
//   obj_type_e   : object kind carried on obj_type (obstacle / banana)
//   state_e      : frame FSM states
//   obj_rec_t    : one table slot (valid, lane, y, kind)
//   lane_of()    : folds a 3-bit randomizer value into the lane range
package obstacle_spawner_pkg;

  // Width of the y field held in a table record; the top's Y_W must not exceed it.
  localparam int unsigned OBJ_Y_W = 7;

  typedef enum logic {
    OBJ_OBSTACLE = 1'b0,
    OBJ_BANANA   = 1'b1
  } obj_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SPAWN,
    ST_EMIT
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [2:0]         lane;
    logic [OBJ_Y_W-1:0] y;
    obj_type_e          kind;
  } obj_rec_t;

  // Values at or above the lane count wrap back by one lane count (5->0, 6->1, 7->2
  // for five lanes); the extra modulo only matters for very small lane counts.
  function automatic logic [2:0] lane_of(input logic [2:0] r, input int unsigned lanes);
    if (32'(r) < lanes) return r;
    return 3'((32'(r) - lanes) % lanes);
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Object stream from the spawner to the renderer / collision logic.
//   obj_valid : word valid (master)
//   obj_ready : consumer accepts word (slave)
//   obj_idx   : slot index of the word
//   obj_lane  : lane 0..LANES-1
//   obj_y     : row
//   obj_type  : 0 obstacle, 1 banana
interface obstacle_spawner_if #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned Y_W   = 7
);
  logic                     obj_valid;
  logic                     obj_ready;
  logic [$clog2(SLOTS)-1:0] obj_idx;
  logic [2:0]               obj_lane;
  logic [Y_W-1:0]           obj_y;
  logic                     obj_type;

  modport master (
    output obj_valid, obj_idx, obj_lane, obj_y, obj_type,
    input  obj_ready
  );

  modport slave (
    input  obj_valid, obj_idx, obj_lane, obj_y, obj_type,
    output obj_ready
  );
endinterface

// File: rtl/obstacle_spawner_lane_map.sv
// Maps the obstacle and banana randomizer values onto road lanes. When the banana
// would land in the obstacle's lane it is bumped one lane to the right (wrapping).
//   rand_obs / rand_ban : raw 3-bit randomizer values
//   obs_lane / ban_lane : resulting lanes
module obstacle_spawner_lane_map
  import obstacle_spawner_pkg::*;
#(
  parameter int unsigned LANES = 5
) (
  input  logic [2:0] rand_obs,
  input  logic [2:0] rand_ban,
  output logic [2:0] obs_lane,
  output logic [2:0] ban_lane
);

  logic [2:0] ban_raw;

  always_comb begin
    obs_lane = lane_of(rand_obs, LANES);
    ban_raw  = lane_of(rand_ban, LANES);
    ban_lane = ban_raw;
    if (ban_raw == obs_lane)
      ban_lane = (obs_lane == 3'(LANES - 1)) ? '0 : obs_lane + 3'd1;
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Object table for the road game. Each honoured frame tick scrolls live objects,
// periodically spawns an obstacle (and every Nth time a banana) into free slots,
// then streams every live slot over the obj interface.
//   clk, reset      : clock, synchronous active-high reset
//   game_en, tick   : frame pulse, honoured only in IDLE with game_en high
//   rand_obs/ban    : lane randomizer values, sampled in the SPAWN cycle
//   clr_en/clr_idx  : retire a slot (collision), IDLE only; clr_ack answers
//   obj             : object stream (master)
//   frame_done      : pulse after the last slot has been walked
//   spawn_drop      : pulse when a spawn found no free slot
//   tick_miss       : pulse when a tick arrived outside IDLE
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int unsigned SLOTS        = 4,
  parameter int unsigned LANES        = 5,
  parameter int unsigned Y_W          = 7,
  parameter int unsigned Y_MAX        = 119,
  parameter int unsigned SPEED        = 1,
  parameter int unsigned SPAWN_PERIOD = 32,
  parameter int unsigned BANANA_EVERY = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     game_en,
  input  logic                     tick,
  input  logic [2:0]               rand_obs,
  input  logic [2:0]               rand_ban,
  input  logic                     clr_en,
  input  logic [$clog2(SLOTS)-1:0] clr_idx,
  output logic                     clr_ack,
  obstacle_spawner_if.master       obj,
  output logic                     frame_done,
  output logic                     spawn_drop,
  output logic                     tick_miss
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned PC_W  = $clog2(SPAWN_PERIOD + 1);
  localparam int unsigned EC_W  = $clog2(BANANA_EVERY + 1);

  state_e          state;
  obj_rec_t        tbl   [SLOTS];
  obj_rec_t        tbl_n [SLOTS];
  logic [PC_W-1:0] period_cnt;
  logic [EC_W-1:0] event_cnt;
  logic            spawn_evt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt_ptr;
  obj_rec_t        nxt_rec;
  logic            drop_n;
  logic [2:0]      obs_lane;
  logic [2:0]      ban_lane;

  obstacle_spawner_lane_map #(.LANES(LANES)) u_lane_map (
    .rand_obs (rand_obs),
    .rand_ban (rand_ban),
    .obs_lane (obs_lane),
    .ban_lane (ban_lane)
  );

  // Next table contents: clear in IDLE, scroll/retire in MOVE, place objects in SPAWN.
  always_comb begin : next_table
    logic [Y_W:0] y_adv;
    logic         ban_due;
    logic         obs_done;
    logic         ban_done;
    tbl_n    = tbl;
    drop_n   = 1'b0;
    y_adv    = '0;
    ban_due  = (event_cnt == EC_W'(BANANA_EVERY - 1));
    obs_done = 1'b0;
    ban_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        for (int unsigned i = 0; i < SLOTS; i++)
          if (clr_en && clr_idx == IDX_W'(i)) tbl_n[i].valid = 1'b0;
      end
      ST_MOVE: begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          if (tbl[i].valid) begin
            // One extra bit so a step past the last row cannot wrap to the top.
            y_adv = {1'b0, tbl[i].y[Y_W-1:0]} + (Y_W + 1)'(SPEED);
            if (y_adv > (Y_W + 1)'(Y_MAX)) tbl_n[i].valid = 1'b0;
            else                           tbl_n[i].y     = OBJ_Y_W'(y_adv[Y_W-1:0]);
          end
        end
      end
      ST_SPAWN: begin
        if (spawn_evt) begin
          // Free slots come from the post-MOVE table; obstacle takes the lowest,
          // a due banana the next one up.
          for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!tbl[i].valid) begin
              if (!obs_done) begin
                tbl_n[i] = '{valid: 1'b1, lane: obs_lane, y: '0, kind: OBJ_OBSTACLE};
                obs_done = 1'b1;
              end else if (ban_due && !ban_done) begin
                tbl_n[i] = '{valid: 1'b1, lane: ban_lane, y: '0, kind: OBJ_BANANA};
                ban_done = 1'b1;
              end
            end
          end
          drop_n = !obs_done || (ban_due && !ban_done);
        end
      end
      default: ;
    endcase
  end

  // Slot to present next: slot 0 when entering EMIT, otherwise the one after ptr.
  always_comb begin
    nxt_ptr = (state == ST_EMIT) ? ptr + 1'b1 : '0;
    nxt_rec = '0;
    for (int unsigned i = 0; i < SLOTS; i++)
      if (nxt_ptr == IDX_W'(i)) nxt_rec = tbl_n[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      for (int unsigned i = 0; i < SLOTS; i++) tbl[i] <= '0;
      period_cnt <= '0;
      event_cnt  <= '0;
      spawn_evt  <= 1'b0;
      ptr        <= '0;
      clr_ack    <= 1'b0;
      frame_done <= 1'b0;
      spawn_drop <= 1'b0;
      tick_miss  <= 1'b0;
      obj.obj_valid <= 1'b0;
      obj.obj_idx   <= '0;
      obj.obj_lane  <= '0;
      obj.obj_y     <= '0;
      obj.obj_type  <= 1'b0;
    end else begin
      tbl        <= tbl_n;
      clr_ack    <= 1'b0;
      frame_done <= 1'b0;
      spawn_drop <= 1'b0;
      tick_miss  <= (state != ST_IDLE) && tick;
      unique case (state)
        ST_IDLE: begin
          clr_ack <= clr_en;
          if (tick && game_en) state <= ST_MOVE;
        end
        ST_MOVE: begin
          if (period_cnt == PC_W'(SPAWN_PERIOD - 1)) begin
            period_cnt <= '0;
            spawn_evt  <= 1'b1;
          end else begin
            period_cnt <= period_cnt + 1'b1;
            spawn_evt  <= 1'b0;
          end
          state <= ST_SPAWN;
        end
        ST_SPAWN: begin
          if (spawn_evt) begin
            event_cnt  <= (event_cnt == EC_W'(BANANA_EVERY - 1)) ? '0 : event_cnt + 1'b1;
            spawn_drop <= drop_n;
          end
          spawn_evt     <= 1'b0;
          ptr           <= '0;
          obj.obj_valid <= nxt_rec.valid;
          obj.obj_idx   <= nxt_ptr;
          obj.obj_lane  <= nxt_rec.lane;
          obj.obj_y     <= nxt_rec.y[Y_W-1:0];
          obj.obj_type  <= nxt_rec.kind;
          state         <= ST_EMIT;
        end
        ST_EMIT: begin
          // An empty slot moves on at once; a live one waits for the handshake.
          if (!obj.obj_valid || obj.obj_ready) begin
            if (ptr == IDX_W'(SLOTS - 1)) begin
              obj.obj_valid <= 1'b0;
              frame_done    <= 1'b1;
              ptr           <= '0;
              state         <= ST_IDLE;
            end else begin
              ptr           <= nxt_ptr;
              obj.obj_valid <= nxt_rec.valid;
              obj.obj_idx   <= nxt_ptr;
              obj.obj_lane  <= nxt_rec.lane;
              obj.obj_y     <= nxt_rec.y[Y_W-1:0];
              obj.obj_type  <= nxt_rec.kind;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
